// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - pipelined WIDTH-bit barrel shifter (LSL/LSR/ASR/ROR), valid/ready on both sides
// Optional carry/zero flag outputs are built when BSHIFT_FLAGS_EN is defined.
module barrel_shifter_pipe #(
   parameter  int WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef BSHIFT_FLAGS_EN
   ,
   output logic             out_carry,
   output logic             out_zero
`endif
);

   localparam logic [1:0] OP_LSL = 2'b00;
   localparam logic [1:0] OP_LSR = 2'b01;
   localparam logic [1:0] OP_ASR = 2'b10;

   function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d, input logic [1:0] op,
                                                input int s);
      case (op)
         OP_LSL:  f_shift = d << s;
         OP_LSR:  f_shift = d >> s;
         OP_ASR:  f_shift = $signed(d) >>> s;
         default: f_shift = (d >> s) | (d << (WIDTH - s));
      endcase
   endfunction

   logic [SHW-1:0]   r_valid;
   logic [WIDTH-1:0] r_data [SHW];
   logic [1:0]       r_op   [SHW];
   logic [SHW-1:0]   r_amt  [SHW];

   logic [SHW-1:0]   w_ready;
   logic [SHW-1:0]   w_up_valid;
   logic [WIDTH-1:0] w_up_data   [SHW];
   logic [1:0]       w_up_op     [SHW];
   logic [SHW-1:0]   w_up_amt    [SHW];
   logic [WIDTH-1:0] w_next_data [SHW];
   logic             w_unused;

`ifdef BSHIFT_FLAGS_EN
   function automatic logic f_carry(input logic [WIDTH-1:0] d, input logic [1:0] op, input int s);
      logic [WIDTH-1:0] v_t;
      if (op == OP_LSL) v_t = d >> (WIDTH - s);
      else              v_t = d >> (s - 1);
      f_carry = v_t[0];
   endfunction

   logic r_carry [SHW];
   logic r_zero;
   logic w_up_carry   [SHW];
   logic w_next_carry [SHW];
`endif

   // Ready ripples backwards from out_ready; a stage is free when empty or draining.
   always_comb begin
      logic v_rdy;
      v_rdy   = out_ready;
      w_ready = '0;
      for (int k = SHW - 1; k >= 0; k--) begin
         v_rdy      = !r_valid[k] || v_rdy;
         w_ready[k] = v_rdy;
      end
   end

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int S = 1 << k;
      if (k == 0) begin : g_first
         assign w_up_valid[k] = in_valid;
         assign w_up_data[k]  = in_data;
         assign w_up_op[k]    = in_op;
         assign w_up_amt[k]   = in_amt;
`ifdef BSHIFT_FLAGS_EN
         assign w_up_carry[k] = 1'b0;
`endif
      end else begin : g_next
         assign w_up_valid[k] = r_valid[k-1];
         assign w_up_data[k]  = r_data[k-1];
         assign w_up_op[k]    = r_op[k-1];
         assign w_up_amt[k]   = r_amt[k-1];
`ifdef BSHIFT_FLAGS_EN
         assign w_up_carry[k] = r_carry[k-1];
`endif
      end
      assign w_next_data[k] = w_up_amt[k][k] ? f_shift(w_up_data[k], w_up_op[k], S) : w_up_data[k];
`ifdef BSHIFT_FLAGS_EN
      assign w_next_carry[k] = w_up_amt[k][k] ? f_carry(w_up_data[k], w_up_op[k], S) : w_up_carry[k];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SHW; k++) begin
            r_valid[k] <= 1'b0;
            r_data[k]  <= '0;
            r_op[k]    <= '0;
            r_amt[k]   <= '0;
`ifdef BSHIFT_FLAGS_EN
            r_carry[k] <= 1'b0;
`endif
         end
`ifdef BSHIFT_FLAGS_EN
         r_zero <= 1'b0;
`endif
      end else begin
         for (int k = 0; k < SHW; k++) begin
            if (w_ready[k]) begin
               r_valid[k] <= w_up_valid[k];
               if (w_up_valid[k]) begin
                  r_data[k] <= w_next_data[k];
                  r_op[k]   <= w_up_op[k];
                  r_amt[k]  <= w_up_amt[k];
`ifdef BSHIFT_FLAGS_EN
                  r_carry[k] <= w_next_carry[k];
`endif
               end
            end
         end
`ifdef BSHIFT_FLAGS_EN
         if (w_ready[SHW-1] && w_up_valid[SHW-1])
            r_zero <= (w_next_data[SHW-1] == '0);
`endif
      end
   end

   // Already-consumed amount bits and the last stage's op are dead by design.
   always_comb begin
      w_unused = 1'b0;
      for (int k = 0; k < SHW; k++)
         w_unused = w_unused ^ (^r_amt[k]) ^ (^r_op[k]);
   end

   assign in_ready  = w_ready[0];
   assign out_valid = r_valid[SHW-1];
   assign out_data  = r_data[SHW-1];
`ifdef BSHIFT_FLAGS_EN
   assign out_carry = r_carry[SHW-1];
   assign out_zero  = r_zero;
`endif

endmodule
